// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// Module      : music_pkg
// Description : Shared state encoding, default widths and note dividers for
//               the melody sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package music_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_t;

  localparam int CLK_HZ     = 25000000;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DIV_W  = 15;
  localparam int DEF_DUR_W  = 4;

  // Half-period divider (clk cycles) for a tone of freq_hz
  function automatic int half_period(input int freq_hz);
    return CLK_HZ / freq_hz / 2;
  endfunction

  localparam int NOTE_A3 = half_period(220);
  localparam int NOTE_A4 = half_period(440);
  localparam int NOTE_A5 = half_period(880);

endpackage
`default_nettype wire

// File: rtl/melody_sequencer_tone.sv
`default_nettype none
// ============================================================================
// Module      : tone_divider
// Description : Loadable half-period down-counter driving a registered square
//               wave; a divider of 0 is a rest and holds the output low.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_divider #(
  parameter int DIV_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tone
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_tone;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (i_load) begin
      r_div  <= i_div;
      r_cnt  <= i_div - DIV_W'(1);
      r_tone <= 1'b0;
    end else if (i_en && (r_div != '0)) begin
      if (r_cnt == '0) begin
        r_cnt  <= r_div - DIV_W'(1);
        r_tone <= ~r_tone;
      end else begin
        r_cnt  <= r_cnt - DIV_W'(1);
      end
    end
  end

  assign o_tone = r_tone;

endmodule
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : melody_sequencer
// Description : Steps through a writable note table, playing each entry as a
//               square wave for its duration followed by a silent gap.
// Revision    : 1.0 - initial release
// ============================================================================
module melody_sequencer
  import music_pkg::*;
#(
  parameter int NOTE_COUNT = 16,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int DUR_W      = DEF_DUR_W,
  parameter int TICK_DIV   = 1562500,
  parameter int GAP_CLKS   = 250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_pulse,
  input  logic              stop_pulse,
  input  logic              loop_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic [DUR_W-1:0]  wr_dur,
  output logic              speaker,
  output logic              busy,
  output logic [ADDR_W-1:0] note_idx,
  output logic              done_pulse
);

  localparam int c_TW = $clog2(TICK_DIV + 1);
  localparam int c_GW = $clog2(GAP_CLKS + 1);
  localparam logic [c_TW-1:0]   c_TICK_LAST = c_TW'(TICK_DIV - 1);
  localparam logic [c_GW-1:0]   c_GAP_LAST  = c_GW'(GAP_CLKS - 1);
  localparam logic [ADDR_W-1:0] c_LAST_IDX  = ADDR_W'(NOTE_COUNT - 1);

  logic [DIV_W-1:0] r_div_tab [NOTE_COUNT];
  logic [DUR_W-1:0] r_dur_tab [NOTE_COUNT];

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic [ADDR_W-1:0] r_note_idx;
  logic [ADDR_W-1:0] w_next_idx;
  logic [c_TW-1:0]   r_tick;
  logic [DUR_W-1:0]  r_rem;
  logic [c_GW-1:0]   r_gap;
  logic              w_done;
  logic [DIV_W-1:0]  w_cur_div;
  logic [DUR_W-1:0]  w_cur_dur;

  // Table storage deliberately has no reset so a song survives rst
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_div_tab[wr_addr] <= wr_div;
      r_dur_tab[wr_addr] <= wr_dur;
    end
  end

  assign w_cur_div = r_div_tab[r_note_idx];
  assign w_cur_dur = r_dur_tab[r_note_idx];

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_note_idx;
    w_done       = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (w_cur_dur == '0) begin
          if (loop_en && (r_note_idx != '0)) begin
            w_next_idx = '0;
          end else begin
            w_next_state = ST_IDLE;
            w_done       = 1'b1;
          end
        end else begin
          w_next_state = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if ((r_tick == '0) && (r_rem == DUR_W'(1))) w_next_state = ST_GAP;
      end
      ST_GAP: begin
        if (r_gap == '0) begin
          if (r_note_idx != c_LAST_IDX) begin
            w_next_idx   = r_note_idx + ADDR_W'(1);
            w_next_state = ST_LOAD;
          end else if (loop_en) begin
            w_next_idx   = '0;
            w_next_state = ST_LOAD;
          end else begin
            w_next_state = ST_IDLE;
            w_done       = 1'b1;
          end
        end
      end
      default: w_next_state = r_state;
    endcase
    // Restart beats a natural end; stop beats everything but rst
    if (play_pulse) begin
      w_next_state = ST_LOAD;
      w_next_idx   = '0;
      w_done       = 1'b0;
    end
    if (stop_pulse) begin
      w_next_state = ST_IDLE;
      w_next_idx   = '0;
      w_done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_note_idx <= '0;
      r_tick     <= '0;
      r_rem      <= '0;
      r_gap      <= '0;
    end else begin
      r_state    <= w_next_state;
      r_note_idx <= w_next_idx;
      r_gap      <= (r_state == ST_GAP) ? (r_gap - c_GW'(1)) : c_GAP_LAST;
      if (r_state == ST_LOAD) begin
        r_tick <= c_TICK_LAST;
        r_rem  <= w_cur_dur;
      end else if (r_state == ST_PLAY) begin
        if (r_tick == '0) begin
          r_tick <= c_TICK_LAST;
          r_rem  <= r_rem - DUR_W'(1);
        end else begin
          r_tick <= r_tick - c_TW'(1);
        end
      end
    end
  end

  tone_divider #(
    .DIV_W (DIV_W)
  ) u_tone (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_next_state != ST_PLAY),
    .i_load (r_state == ST_LOAD),
    .i_en   (r_state == ST_PLAY),
    .i_div  (w_cur_div),
    .o_tone (speaker)
  );

  assign busy       = (r_state != ST_IDLE);
  assign note_idx   = r_note_idx;
  assign done_pulse = w_done;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_melody_sequencer
// Description : Directed self-checking bench with TICK_DIV=4, GAP_CLKS=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_sequencer;

  logic       clk;
  logic       rst;
  logic       play_pulse;
  logic       stop_pulse;
  logic       loop_en;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [14:0] wr_div;
  logic [3:0] wr_dur;
  logic       speaker;
  logic       busy;
  logic [3:0] note_idx;
  logic       done_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       play;
    logic       stop;
    logic       sp;
    logic       busy;
    logic [3:0] idx;
    logic       done;
  } vec_t;

  vec_t vecs[14];

  melody_sequencer #(
    .NOTE_COUNT (16),
    .ADDR_W     (4),
    .DIV_W      (15),
    .DUR_W      (4),
    .TICK_DIV   (4),
    .GAP_CLKS   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .play_pulse (play_pulse),
    .stop_pulse (stop_pulse),
    .loop_en    (loop_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_div     (wr_div),
    .wr_dur     (wr_dur),
    .speaker    (speaker),
    .busy       (busy),
    .note_idx   (note_idx),
    .done_pulse (done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d, input int u);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_div  = 15'(d);
    wr_dur  = 4'(u);
    next_cycle();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_play();
    play_pulse = 1'b1;
    next_cycle();
    play_pulse = 1'b0;
  endtask

  task automatic run_until_done(input int bound, output int cycles, output logic [3:0] idx);
    cycles = -1;
    idx    = '0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done_pulse) begin
        cycles = k;
        idx    = note_idx;
        next_cycle();
        break;
      end
      next_cycle();
    end
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < 14; i++) begin
      play_pulse = vecs[i].play;
      stop_pulse = vecs[i].stop;
      @(negedge clk);
      check({tag, "_speaker"}, speaker, vecs[i].sp);
      check({tag, "_busy"}, busy, vecs[i].busy);
      check({tag, "_idx"}, note_idx, vecs[i].idx);
      check({tag, "_done"}, done_pulse, vecs[i].done);
      next_cycle();
    end
    play_pulse = 1'b0;
    stop_pulse = 1'b0;
  endtask

  initial begin
    int          cyc;
    int          n1;
    int          nd;
    int          nb;
    logic [3:0]  didx;

    // Single note {div=2,dur=2}: LOAD@1, PLAY 2-9, GAP 10-11, end-marker LOAD@12
    for (int c = 0; c < 14; c++) begin
      vecs[c].play = (c == 0);
      vecs[c].stop = 1'b0;
      vecs[c].sp   = ((c >= 4) && (c <= 5)) || ((c >= 8) && (c <= 9));
      vecs[c].busy = (c >= 1) && (c <= 12);
      vecs[c].idx  = (c >= 12) ? 4'd1 : 4'd0;
      vecs[c].done = (c == 12);
    end

    rst = 1'b1; play_pulse = 1'b0; stop_pulse = 1'b0; loop_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_div = '0; wr_dur = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_speaker", speaker, 0);
    check("reset_busy", busy, 0);
    check("reset_idx", note_idx, 0);
    check("reset_done", done_pulse, 0);
    next_cycle();

    wr(0, 2, 2);
    wr(1, 0, 0);
    run_vectors("single");

    // Rest entry: speaker silent for the whole 12-cycle PLAY
    wr(0, 0, 3);
    pulse_play();
    next_cycle();
    for (int c = 2; c <= 13; c++) begin
      @(negedge clk);
      check("rest_speaker", speaker, 0);
      check("rest_busy", busy, 1);
      next_cycle();
    end
    run_until_done(20, cyc, didx);
    check("rest_done_latency", cyc, 2);

    // Loop: period 8 cycles, note_idx=1 once per period, never done
    loop_en = 1'b1;
    wr(0, 3, 1);
    pulse_play();
    n1 = 0; nd = 0; nb = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (note_idx == 4'd1) n1++;
      if (done_pulse) nd++;
      if (!busy) nb++;
      next_cycle();
    end
    check("loop_idx1_count", n1, 8);
    check("loop_no_done", nd, 0);
    check("loop_stays_busy", nb, 0);
    wr(0, 3, 0);
    run_until_done(40, cyc, didx);
    check("loop_empty_done_found", (cyc >= 0), 1);
    @(negedge clk);
    check("loop_empty_idle", busy, 0);
    next_cycle();
    loop_en = 1'b0;

    // Stop mid-note while speaker is high
    wr(0, 2, 2);
    pulse_play();
    cyc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (speaker) begin cyc = k; break; end
      next_cycle();
    end
    check("stop_speaker_high_seen", (cyc >= 0), 1);
    stop_pulse = 1'b1;
    next_cycle();
    stop_pulse = 1'b0;
    @(negedge clk);
    check("stop_busy", busy, 0);
    check("stop_speaker", speaker, 0);
    check("stop_idx", note_idx, 0);
    check("stop_done", done_pulse, 0);
    next_cycle();

    // Stop and play together: stop wins
    pulse_play();
    next_cycle();
    next_cycle();
    play_pulse = 1'b1;
    stop_pulse = 1'b1;
    next_cycle();
    play_pulse = 1'b0;
    stop_pulse = 1'b0;
    @(negedge clk);
    check("stop_play_busy", busy, 0);
    next_cycle();

    // Restart while speaker is high
    pulse_play();
    repeat (3) next_cycle();
    @(negedge clk);
    check("restart_pre_speaker", speaker, 1);
    play_pulse = 1'b1;
    next_cycle();
    play_pulse = 1'b0;
    @(negedge clk);
    check("restart_busy", busy, 1);
    check("restart_speaker", speaker, 0);
    check("restart_idx", note_idx, 0);
    next_cycle();

    // Play coincident with natural end: restart, no done_pulse
    stop_pulse = 1'b1;
    next_cycle();
    stop_pulse = 1'b0;
    pulse_play();
    repeat (11) next_cycle();
    play_pulse = 1'b1;
    @(negedge clk);
    check("end_restart_no_done", done_pulse, 0);
    check("end_restart_idx_before", note_idx, 1);
    next_cycle();
    play_pulse = 1'b0;
    @(negedge clk);
    check("end_restart_busy", busy, 1);
    check("end_restart_idx", note_idx, 0);
    next_cycle();
    stop_pulse = 1'b1;
    next_cycle();
    stop_pulse = 1'b0;

    // Reset during PLAY, then identical replay from the preserved table
    pulse_play();
    repeat (5) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_speaker", speaker, 0);
    check("midrst_busy", busy, 0);
    check("midrst_idx", note_idx, 0);
    check("midrst_done", done_pulse, 0);
    next_cycle();
    run_vectors("replay");

    // End of table: 16 one-tick notes, 7 cycles each
    for (int a = 0; a < 16; a++) wr(a, 2, 1);
    pulse_play();
    run_until_done(300, cyc, didx);
    check("eot_done_cycle", cyc, 111);
    check("eot_done_idx", didx, 15);
    @(negedge clk);
    check("eot_idle", busy, 0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
